// File: rtl/matmul_pkg.sv
// Shared matmul definitions: default operand/accumulator sizes, MAC latency,
// FSM state encoding and the row-major element index helper.
package matmul_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 16;
  localparam int DEF_DIM        = 3;
  localparam int DEF_MAC_LAT    = 2;
  localparam int IDX_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row-major flat index of element (row, col) in a dim x dim matrix.
  function automatic logic [IDX_W-1:0] elem_idx(input int row, input int col, input int dim);
    return IDX_W'(row * dim + col);
  endfunction

endpackage

// File: rtl/mat_feeder_valid_pipe.sv
// valid_pipe: DEPTH-stage shift register carrying a valid flag and an element
// index, so each result lines up with the MAC output that belongs to it.
module valid_pipe
  import matmul_pkg::*;
#(
  parameter int DEPTH     = DEF_MAC_LAT,
  parameter int IDX_WIDTH = IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IDX_WIDTH-1:0] in_idx,
  output logic                 out_valid,
  output logic [IDX_WIDTH-1:0] out_idx
);

  logic [DEPTH-1:0]     valid_q;
  logic [IDX_WIDTH-1:0] idx_q [DEPTH];

  // Shift valid and index one stage per clock; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        idx_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= in_idx;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        idx_q[s]   <= idx_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/mat_feeder.sv
// mat_feeder: holds two DIM x DIM operand matrices and streams every (row, col)
// pair to a downstream MAC, then tags the returning sums with their C index.
// Optional result buffer with combinational read port: MAT_FEEDER_RESULT_BUF_EN.
module mat_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DIM        = DEF_DIM,
  parameter int MAC_LAT    = DEF_MAC_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic                      load_sel,
  input  logic [3:0]                load_addr,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      go,
  output logic                      busy,
  output logic [DATA_WIDTH*DIM-1:0] row_out,
  output logic [DATA_WIDTH*DIM-1:0] col_out,
  output logic                      mac_start,
  input  logic [ACC_WIDTH-1:0]      mac_result,
  output logic                      res_valid,
  output logic [3:0]                res_idx,
  output logic [ACC_WIDTH-1:0]      res_data,
  output logic                      done
`ifdef MAT_FEEDER_RESULT_BUF_EN
  ,
  input  logic [3:0]                rd_addr,
  output logic [ACC_WIDTH-1:0]      rd_data
`endif
);

  localparam int NELEM   = DIM * DIM;
  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t               state;
  state_t               next_state;
  logic [IDX_W-1:0]     i_cnt;
  logic [IDX_W-1:0]     j_cnt;
  logic [IDX_W-1:0]     k;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 issue;
  logic                 load_ok;
  logic [DATA_WIDTH-1:0] a_mem [NELEM];
  logic [DATA_WIDTH-1:0] b_mem [NELEM];
  logic                 pipe_valid;
  logic [IDX_W-1:0]     pipe_idx;

  assign k = elem_idx(int'(i_cnt), int'(j_cnt), DIM);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    mac_start  = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        mac_start = 1'b1;
        issue     = 1'b1;
        if (k == IDX_W'(NELEM - 1)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        mac_start = 1'b1;
        if (drain_cnt == DRAIN_W'(MAC_LAT - 1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Walk (i, j) with j fastest while issuing; count drain cycles; idle at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt     <= '0;
      j_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      if (issue) begin
        if (j_cnt == IDX_W'(DIM - 1)) begin
          j_cnt <= '0;
          i_cnt <= i_cnt + IDX_W'(1);
        end else begin
          j_cnt <= j_cnt + IDX_W'(1);
        end
      end else begin
        i_cnt <= '0;
        j_cnt <= '0;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // Loads only land while idle (including the go cycle) and at in-range addresses.
  assign load_ok = load_valid && !busy && (load_addr < IDX_W'(NELEM));

  // Operand storage; persists across runs until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NELEM; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else if (load_ok) begin
      if (load_sel) begin
        b_mem[load_addr] <= load_data;
      end else begin
        a_mem[load_addr] <= load_data;
      end
    end
  end

  // Present row i of A and column j of B, element 0 in the MSBs, only while issuing.
  always_comb begin
    row_out = '0;
    col_out = '0;
    if (issue) begin
      for (int e = 0; e < DIM; e++) begin
        row_out[(DIM-1-e)*DATA_WIDTH +: DATA_WIDTH] = a_mem[elem_idx(int'(i_cnt), e, DIM)];
        col_out[(DIM-1-e)*DATA_WIDTH +: DATA_WIDTH] = b_mem[elem_idx(e, int'(j_cnt), DIM)];
      end
    end
  end

  valid_pipe #(
    .DEPTH     (MAC_LAT),
    .IDX_WIDTH (IDX_W)
  ) u_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_idx    (issue ? k : '0),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  assign res_valid = pipe_valid;
  assign res_idx   = pipe_idx;
  assign res_data  = pipe_valid ? mac_result : '0;

`ifdef MAT_FEEDER_RESULT_BUF_EN
  logic [ACC_WIDTH-1:0] res_buf [NELEM];

  // Capture every tagged result at its C index for later random access.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NELEM; e++) begin
        res_buf[e] <= '0;
      end
    end else if (res_valid && (res_idx < IDX_W'(NELEM))) begin
      res_buf[res_idx] <= mac_result;
    end
  end

  assign rd_data = (rd_addr < IDX_W'(NELEM)) ? res_buf[rd_addr] : '0;
`endif

endmodule

// File: tb/tb_mat_feeder.sv
// Directed bench for mat_feeder with a behavioural two-stage downstream MAC.
module tb_mat_feeder;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_sel;
  logic [3:0]  load_addr;
  logic [7:0]  load_data;
  logic        go;
  logic        busy;
  logic [23:0] row_out;
  logic [23:0] col_out;
  logic        mac_start;
  logic [15:0] mac_result;
  logic        res_valid;
  logic [3:0]  res_idx;
  logic [15:0] res_data;
  logic        done;
`ifdef MAT_FEEDER_RESULT_BUF_EN
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
`endif

  int vectors;
  int miscompares;

  logic [7:0] ma [9];
  logic [7:0] mb [9];
  int         exp_c [9];
  logic [15:0] mac_p1;

  mat_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_sel   (load_sel),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .go         (go),
    .busy       (busy),
    .row_out    (row_out),
    .col_out    (col_out),
    .mac_start  (mac_start),
    .mac_result (mac_result),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_data   (res_data),
    .done       (done)
`ifdef MAT_FEEDER_RESULT_BUF_EN
    ,
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-element dot product, truncated to the 16-bit accumulator.
  function automatic logic [15:0] dot3(input logic [23:0] r, input logic [23:0] c);
    int s;
    s = 0;
    for (int e = 0; e < 3; e++) begin
      s = s + int'(r[(2-e)*8 +: 8]) * int'(c[(2-e)*8 +: 8]);
    end
    return s[15:0];
  endfunction

  // Downstream MAC: product registered once, sum registered again (two cycles).
  always @(posedge clk) begin
    mac_p1     <= dot3(row_out, col_out);
    mac_result <= mac_p1;
  end

  function automatic logic [23:0] rowOf(input int kk);
    int i;
    i = kk / 3;
    return {ma[i*3], ma[i*3+1], ma[i*3+2]};
  endfunction

  function automatic logic [23:0] colOf(input int kk);
    int j;
    j = kk % 3;
    return {mb[j], mb[3+j], mb[6+j]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle operand load; the bench model follows only in-range addresses.
  task automatic applyStimulus(input logic sel, input int addr, input logic [7:0] data);
    @(posedge clk);
    #1;
    go         = 1'b0;
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = 4'(addr);
    load_data  = data;
    if (addr < 9) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  // go in cycle 0, optional B load in the go cycle, optional extra go, mid-run
  // load of A[0]=77, or reset; every output checked each cycle through cycle 18.
  task automatic runMultiply(input string name, input int gl_addr, input logic [7:0] gl_data,
                             input int go_again, input int load_at, input int reset_at);
    bit ab, e_busy, e_ms, e_issue, e_rv, e_done;
    @(posedge clk);
    #1;
    go         = 1'b1;
    reset      = 1'b0;
    load_valid = (gl_addr >= 0);
    load_sel   = 1'b1;
    load_addr  = 4'(gl_addr);
    load_data  = gl_data;
    if (gl_addr >= 0 && gl_addr < 9) mb[gl_addr] = gl_data;
    @(negedge clk);
    checkOutput($sformatf("%s c0 busy", name), 32'(busy), 32'd0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(posedge clk);
      #1;
      go         = (cyc == go_again);
      load_valid = (cyc == load_at);
      load_sel   = 1'b0;
      load_addr  = 4'd0;
      load_data  = 8'd77;
      reset      = (cyc == reset_at);
      @(negedge clk);
      ab      = (reset_at >= 0) && (cyc > reset_at);
      e_busy  = !ab && cyc <= 12;
      e_ms    = !ab && cyc <= 11;
      e_issue = !ab && cyc <= 9;
      e_rv    = !ab && cyc >= 3 && cyc <= 11;
      e_done  = !ab && cyc == 12;
      checkOutput($sformatf("%s c%0d busy", name, cyc), 32'(busy), 32'(e_busy));
      checkOutput($sformatf("%s c%0d mac_start", name, cyc), 32'(mac_start), 32'(e_ms));
      checkOutput($sformatf("%s c%0d done", name, cyc), 32'(done), 32'(e_done));
      checkOutput($sformatf("%s c%0d res_valid", name, cyc), 32'(res_valid), 32'(e_rv));
      checkOutput($sformatf("%s c%0d row_out", name, cyc), 32'(row_out),
                  e_issue ? 32'(rowOf(cyc-1)) : 32'd0);
      checkOutput($sformatf("%s c%0d col_out", name, cyc), 32'(col_out),
                  e_issue ? 32'(colOf(cyc-1)) : 32'd0);
      if (e_rv) begin
        checkOutput($sformatf("%s c%0d res_idx", name, cyc), 32'(res_idx), 32'(cyc-3));
        checkOutput($sformatf("%s c%0d res_data", name, cyc), 32'(res_data), 32'(exp_c[cyc-3]));
      end else if (ab) begin
        checkOutput($sformatf("%s c%0d res_idx", name, cyc), 32'(res_idx), 32'd0);
        checkOutput($sformatf("%s c%0d res_data", name, cyc), 32'(res_data), 32'd0);
      end
    end
    go         = 1'b0;
    load_valid = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mac_p1      = '0;
    mac_result  = '0;
    reset       = 1'b1;
    load_valid  = 1'b0;
    load_sel    = 1'b0;
    load_addr   = 4'd0;
    load_data   = 8'd0;
    go          = 1'b0;
`ifdef MAT_FEEDER_RESULT_BUF_EN
    rd_addr     = 4'd0;
`endif
    for (int e = 0; e < 9; e++) begin
      ma[e] = 8'd0;
      mb[e] = 8'd0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mac_start", 32'(mac_start), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset row_out", 32'(row_out), 32'd0);
    checkOutput("reset col_out", 32'(col_out), 32'd0);
    checkOutput("reset res_idx", 32'(res_idx), 32'd0);
    checkOutput("reset res_data", 32'(res_data), 32'd0);
    reset = 1'b0;

    $display("[TB] identity run");
    for (int e = 0; e < 9; e++) applyStimulus(1'b0, e, (e % 4 == 0) ? 8'd1 : 8'd0);
    for (int e = 0; e < 8; e++) applyStimulus(1'b1, e, 8'(e + 1));
    applyStimulus(1'b0, 12, 8'd99);
    for (int e = 0; e < 9; e++) exp_c[e] = e + 1;
    runMultiply("ident", 8, 8'd9, -1, -1, -1);
`ifdef MAT_FEEDER_RESULT_BUF_EN
    rd_addr = 4'd4;
    #1;
    checkOutput("rdbuf addr4", 32'(rd_data), 32'd5);
    rd_addr = 4'd12;
    #1;
    checkOutput("rdbuf addr12", 32'(rd_data), 32'd0);
`endif

    $display("[TB] uniform run");
    for (int e = 0; e < 9; e++) applyStimulus(1'b0, e, 8'd16);
    for (int e = 0; e < 9; e++) applyStimulus(1'b1, e, 8'd16);
    for (int e = 0; e < 9; e++) exp_c[e] = 768;
    runMultiply("unif", -1, 8'd0, -1, -1, -1);

    $display("[TB] wrap run and repeat");
    for (int e = 0; e < 9; e++) applyStimulus(1'b0, e, 8'd255);
    for (int e = 0; e < 9; e++) applyStimulus(1'b1, e, 8'd255);
    for (int e = 0; e < 9; e++) exp_c[e] = 64003;
    runMultiply("wrap", -1, 8'd0, -1, -1, -1);
    runMultiply("rerun", -1, 8'd0, -1, -1, -1);

    $display("[TB] go and load while busy");
    for (int e = 0; e < 9; e++) applyStimulus(1'b0, e, (e % 4 == 0) ? 8'd1 : 8'd0);
    for (int e = 0; e < 9; e++) applyStimulus(1'b1, e, 8'(e + 1));
    for (int e = 0; e < 9; e++) exp_c[e] = e + 1;
    runMultiply("busygo", -1, 8'd0, 5, 6, -1);
    runMultiply("afterbusy", -1, 8'd0, -1, -1, -1);

    $display("[TB] reset mid-run");
    runMultiply("abort", -1, 8'd0, -1, -1, 6);
    for (int e = 0; e < 9; e++) begin
      ma[e]    = 8'd0;
      mb[e]    = 8'd0;
      exp_c[e] = 0;
    end
    runMultiply("cleared", -1, 8'd0, -1, -1, -1);
    for (int e = 0; e < 9; e++) applyStimulus(1'b0, e, 8'(e + 1));
    applyStimulus(1'b1, 0, 8'd2);
    applyStimulus(1'b1, 4, 8'd2);
    applyStimulus(1'b1, 8, 8'd2);
    for (int e = 0; e < 9; e++) exp_c[e] = 2 * (e + 1);
    runMultiply("postreset", -1, 8'd0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
